// File: rtl/read_burst_assembler.sv
// ============================================================================
// Module   : read_burst_assembler
// Brief    : Packs DDR rise/fall beat pairs into BL8/BC4 bursts, queued in a
//            small valid/ready output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_burst_assembler #(
  parameter int BW    = 8,
  parameter int BL    = 8,
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_start,
  input  logic              bc4,
  input  logic              data_valid,
  input  logic [BW-1:0]     data_rise,
  input  logic [BW-1:0]     data_fall,
  output logic [BW*BL-1:0]  out_data,
  output logic              out_chop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int WW = BW * BL;
  localparam int CW = $clog2(BL + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_chop;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_target;
  logic [WW-1:0]   r_asm;
  logic [WW-1:0]   w_asm_next;

  logic            w_new_chop;
  logic [CW-1:0]   w_new_target;
  logic            w_final;
  logic            w_pop;
  logic            w_full;
  logic            w_push;

  logic [WW-1:0]   r_mem      [DEPTH];
  logic            r_mem_chop [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [FW-1:0]   r_count;
  logic            r_overflow;

  // Chop is only meaningful for a full BL8 configuration.
  assign w_new_chop   = bc4 && (BL == 8);
  assign w_new_target = w_new_chop ? CW'(4) : CW'(BL);

  assign w_final = (r_state == COLLECT) && data_valid &&
                   (({1'b0, r_cnt} + (CW+1)'(2)) == {1'b0, r_target});

  assign w_pop  = (r_count != '0) && out_ready;
  assign w_full = (r_count == FW'(DEPTH));
  assign w_push = w_final && (!w_full || w_pop);

  // Beat k lands at out_data[BW*(BL-k)-1 -: BW], first beat in the MSBs.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < BL; k++) begin
      if (k == int'(r_cnt))
        w_asm_next[BW*(BL-k)-1 -: BW] = data_rise;
      if (k == int'(r_cnt) + 1)
        w_asm_next[BW*(BL-k)-1 -: BW] = data_fall;
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1))
      return '0;
    else
      return p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_chop   <= 1'b0;
      r_cnt    <= '0;
      r_target <= '0;
      r_asm    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rd_start) begin
            r_state  <= COLLECT;
            r_chop   <= w_new_chop;
            r_target <= w_new_target;
            r_cnt    <= '0;
            r_asm    <= '0;
          end
        end
        COLLECT: begin
          if (data_valid) begin
            if (w_final) begin
              // A start on the final pair chains straight into the next burst.
              if (rd_start) begin
                r_state  <= COLLECT;
                r_chop   <= w_new_chop;
                r_target <= w_new_target;
                r_cnt    <= '0;
                r_asm    <= '0;
              end else begin
                r_state  <= IDLE;
              end
            end else begin
              r_asm <= w_asm_next;
              r_cnt <= r_cnt + CW'(2);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]      <= '0;
        r_mem_chop[i] <= 1'b0;
      end
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      // When full with a pop, wr_ptr equals rd_ptr: the slot being freed is reused.
      if (w_push) begin
        r_mem[r_wr_ptr]      <= w_asm_next;
        r_mem_chop[r_wr_ptr] <= r_chop;
        r_wr_ptr             <= ptr_inc(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_final && !w_push)
        r_overflow <= 1'b1;
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_chop  = r_mem_chop[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign busy      = (r_state == COLLECT);
  assign overflow  = r_overflow;

endmodule

`default_nettype wire
